bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb.sv | 139 +++++++++++++
 tb/tb_bus_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
// bus_arb: registered bus arbiter for NSRC sources.
//
// Each rising edge the block samples every source's drive request and data
// word, picks one winner and registers the winner's word onto the bus. The
// request-to-bus latency is one cycle. No input reaches an output without
// passing through a register.
//
// Parameters
//   WIDTH  data width of every source word and of the bus
//   NSRC   number of sources (2..32)
//   MODE   0 = fixed priority (lowest index wins), 1 = round-robin
//   HOLD   1 = bus keeps its last value when idle, 0 = bus cleared when idle
//
// Ports
//   clk           system clock, rising edge
//   clr           asynchronous active-low reset
//   src_data      packed source words, source i at [i*WIDTH +: WIDTH]
//   src_out       per-source drive request
//   cnt_clr       synchronous clear of conflict_cnt (wins over increment)
//   bus           registered bus value
//   bus_valid     bus was driven by a granted source on the last edge
//   grant         registered one-hot grant, zero when idle
//   grant_idx     binary index of the last granted source
//   conflict      high for one cycle after two or more requests were seen
//   conflict_cnt  saturating count of conflict cycles
module bus_arb #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 24,
    parameter int MODE  = 0,
    parameter int HOLD  = 1,
    localparam int IW   = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  cnt_clr,
    output logic [WIDTH-1:0]      bus,
    output logic                  bus_valid,
    output logic [NSRC-1:0]       grant,
    output logic [IW-1:0]         grant_idx,
    output logic                  conflict,
    output logic [7:0]            conflict_cnt
);

    // NSRC expressed at the width used for the round-robin wrap arithmetic.
    localparam logic [IW:0] NSRC_W = (IW+1)'(NSRC);

    logic [WIDTH-1:0] words_p0 [NSRC];
    logic             any_p0;
    logic             multi_p0;
    logic [IW-1:0]    win_fp_p0;
    logic [IW-1:0]    win_rr_p0;
    logic [IW-1:0]    win_p0;
    logic [IW-1:0]    rr_ptr;
    logic [IW:0]      rr_sum;
    logic [IW-1:0]    rr_cand;
    logic             rr_found;

    // ---- stage p0: combinational request decode ----
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            words_p0[i] = src_data[i*WIDTH +: WIDTH];
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign any_p0   = |src_out;
    assign multi_p0 = |(src_out & (src_out - NSRC'(1)));

    // Fixed priority: scanning downward lets the lowest asserted index win.
    always_comb begin
        win_fp_p0 = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_fp_p0 = IW'(i);
            end
        end
    end

    // Round-robin: search ptr+1 .. ptr+NSRC modulo NSRC. The last candidate
    // is the pointer itself, so a lone request at the pointer still wins
    // after a full wrap. Wrapped candidates always stay below NSRC.
    always_comb begin
        win_rr_p0 = '0;
        rr_found  = 1'b0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NSRC; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (rr_sum >= NSRC_W) begin
                rr_sum = rr_sum - NSRC_W;
            end
            rr_cand = rr_sum[IW-1:0];
            if (!rr_found && src_out[rr_cand]) begin
                win_rr_p0 = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

    assign win_p0 = (MODE == 1) ? win_rr_p0 : win_fp_p0;

    // ---- stage p1: registered outputs ----
    // Pointer resets to NSRC-1 so the first round-robin search starts at 0.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus          <= '0;
            bus_valid    <= 1'b0;
            grant        <= '0;
            grant_idx    <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
            rr_ptr       <= IW'(NSRC - 1);
        end else begin
            conflict <= multi_p0;
            if (cnt_clr) begin
                conflict_cnt <= '0;
            end else if (multi_p0 && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end

            if (any_p0) begin
                bus       <= words_p0[win_p0];
                bus_valid <= 1'b1;
                grant     <= NSRC'(1) << win_p0;
                grant_idx <= win_p0;
                rr_ptr    <= win_p0;
            end else begin
                bus_valid <= 1'b0;
                grant     <= '0;
                if (HOLD == 0) begin
                    bus <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed bench for bus_arb.
// Three instances share the same stimulus: fixed priority with hold,
// fixed priority without hold, and round-robin with hold.
module tb_bus_arb;

    localparam int W  = 32;
    localparam int N  = 24;
    localparam int IW = $clog2(N);

    logic            clk;
    logic            clr;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_out;
    logic            cnt_clr;

    logic [W-1:0]  fp_bus,   fz_bus,   rr_bus;
    logic          fp_valid, fz_valid, rr_valid;
    logic [N-1:0]  fp_grant, fz_grant, rr_grant;
    logic [IW-1:0] fp_idx,   fz_idx,   rr_idx;
    logic          fp_conf,  fz_conf,  rr_conf;
    logic [7:0]    fp_cnt,   fz_cnt,   rr_cnt;

    int checks = 0;
    int errors = 0;

    bus_arb #(.WIDTH(W), .NSRC(N), .MODE(0), .HOLD(1)) u_fp (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .cnt_clr(cnt_clr),
        .bus(fp_bus), .bus_valid(fp_valid), .grant(fp_grant), .grant_idx(fp_idx),
        .conflict(fp_conf), .conflict_cnt(fp_cnt)
    );

    bus_arb #(.WIDTH(W), .NSRC(N), .MODE(0), .HOLD(0)) u_fz (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .cnt_clr(cnt_clr),
        .bus(fz_bus), .bus_valid(fz_valid), .grant(fz_grant), .grant_idx(fz_idx),
        .conflict(fz_conf), .conflict_cnt(fz_cnt)
    );

    bus_arb #(.WIDTH(W), .NSRC(N), .MODE(1), .HOLD(1)) u_rr (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .cnt_clr(cnt_clr),
        .bus(rr_bus), .bus_valid(rr_valid), .grant(rr_grant), .grant_idx(rr_idx),
        .conflict(rr_conf), .conflict_cnt(rr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] onehot(input logic v, input int i);
        if (!v) return 32'h0;
        return 32'h1 << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_fp(input string tag, input logic v, input logic c,
                            input logic [7:0] n, input int idx);
        check({tag, " fp bus"},    fp_bus,          word(idx));
        check({tag, " fp valid"},  32'(fp_valid),   32'(v));
        check({tag, " fp grant"},  32'(fp_grant),   onehot(v, idx));
        check({tag, " fp idx"},    32'(fp_idx),     32'(idx));
        check({tag, " fp conf"},   32'(fp_conf),    32'(c));
        check({tag, " fp cnt"},    32'(fp_cnt),     32'(n));
        check({tag, " fz bus"},    fz_bus,          v ? word(idx) : 32'h0);
        check({tag, " fz grant"},  32'(fz_grant),   onehot(v, idx));
    endtask

    task automatic check_rr(input string tag, input logic v, input logic c,
                            input logic [7:0] n, input int idx);
        check({tag, " rr bus"},    rr_bus,          word(idx));
        check({tag, " rr valid"},  32'(rr_valid),   32'(v));
        check({tag, " rr grant"},  32'(rr_grant),   onehot(v, idx));
        check({tag, " rr idx"},    32'(rr_idx),     32'(idx));
        check({tag, " rr conf"},   32'(rr_conf),    32'(c));
        check({tag, " rr cnt"},    32'(rr_cnt),     32'(n));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " fp bus"},   fp_bus,         32'h0);
        check({tag, " fp valid"}, 32'(fp_valid),  32'h0);
        check({tag, " fp grant"}, 32'(fp_grant),  32'h0);
        check({tag, " fp idx"},   32'(fp_idx),    32'h0);
        check({tag, " fp conf"},  32'(fp_conf),   32'h0);
        check({tag, " fp cnt"},   32'(fp_cnt),    32'h0);
        check({tag, " fz bus"},   fz_bus,         32'h0);
        check({tag, " rr bus"},   rr_bus,         32'h0);
        check({tag, " rr idx"},   32'(rr_idx),    32'h0);
        check({tag, " rr cnt"},   32'(rr_cnt),    32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         cc;
        logic         valid;
        logic         conf;
        logic [7:0]   cnt;
        int           idx_fp;
        int           idx_rr;
    } vec_t;

    vec_t vecs [13];
    int   rot [5];

    initial begin
        // req, cnt_clr, valid, conflict, cnt, fixed winner, round-robin winner
        vecs[0]  = '{24'h000020, 1'b0, 1'b1, 1'b0, 8'd0, 5,  5};
        vecs[1]  = '{24'h000000, 1'b0, 1'b0, 1'b0, 8'd0, 5,  5};
        vecs[2]  = '{24'h000088, 1'b0, 1'b1, 1'b1, 8'd1, 3,  7};
        vecs[3]  = '{24'h000088, 1'b0, 1'b1, 1'b1, 8'd2, 3,  3};
        vecs[4]  = '{24'h000088, 1'b0, 1'b1, 1'b1, 8'd3, 3,  7};
        vecs[5]  = '{24'h800011, 1'b0, 1'b1, 1'b1, 8'd4, 0,  23};
        vecs[6]  = '{24'h800011, 1'b0, 1'b1, 1'b1, 8'd5, 0,  0};
        vecs[7]  = '{24'h800011, 1'b0, 1'b1, 1'b1, 8'd6, 0,  4};
        vecs[8]  = '{24'h800011, 1'b1, 1'b1, 1'b1, 8'd0, 0,  23};
        vecs[9]  = '{24'h800000, 1'b0, 1'b1, 1'b0, 8'd0, 23, 23};
        vecs[10] = '{24'h000000, 1'b0, 1'b0, 1'b0, 8'd0, 23, 23};
        vecs[11] = '{24'hFFFFFF, 1'b0, 1'b1, 1'b1, 8'd1, 0,  0};
        vecs[12] = '{24'hC00000, 1'b0, 1'b1, 1'b1, 8'd2, 22, 22};
        rot = '{0, 4, 23, 0, 4};

        for (int i = 0; i < N; i++) begin
            src_data[i*W +: W] = word(i);
        end
        src_out = '0;
        cnt_clr = 1'b0;
        clr     = 1'b0;

        // Reset state
        tick();
        tick();
        check_zero("reset");
        @(negedge clk);
        clr = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 13; v++) begin
            src_out = vecs[v].req;
            cnt_clr = vecs[v].cc;
            tick();
            check_fp($sformatf("vec%0d", v), vecs[v].valid, vecs[v].conf, vecs[v].cnt, vecs[v].idx_fp);
            check_rr($sformatf("vec%0d", v), vecs[v].valid, vecs[v].conf, vecs[v].cnt, vecs[v].idx_rr);
        end

        // Round-robin rotation from reset
        src_out = '0;
        cnt_clr = 1'b0;
        clr     = 1'b0;
        tick();
        @(negedge clk);
        clr     = 1'b1;
        src_out = 24'h800011;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_rr($sformatf("rot%0d", c), 1'b1, 1'b1, 8'(c + 1), rot[c]);
            check($sformatf("rot%0d fp idx", c), 32'(fp_idx), 32'd0);
        end

        // Saturation: 300 more conflict cycles
        src_out = 24'h000088;
        for (int c = 0; c < 300; c++) begin
            tick();
        end
        check("sat fp cnt", 32'(fp_cnt), 32'd255);
        check("sat rr cnt", 32'(rr_cnt), 32'd255);
        check("sat fp idx", 32'(fp_idx), 32'd3);
        check("sat rr idx", 32'(rr_idx), 32'd3);

        // Clear during a conflict: clear wins, pulse still raised
        cnt_clr = 1'b1;
        tick();
        check_fp("cntclr", 1'b1, 1'b1, 8'd0, 3);
        check_rr("cntclr", 1'b1, 1'b1, 8'd0, 7);
        cnt_clr = 1'b0;
        tick();
        check("after clr fp cnt", 32'(fp_cnt), 32'd1);

        // Build up count 10 with the bus valid, then async reset mid-cycle
        for (int c = 0; c < 9; c++) begin
            tick();
        end
        check_fp("pre-rst", 1'b1, 1'b1, 8'd10, 3);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_zero("async rst");
        tick();
        check_zero("held rst");
        @(negedge clk);
        clr     = 1'b1;
        src_out = 24'h000204;
        tick();
        check_rr("post-rst", 1'b1, 1'b1, 8'd1, 2);
        check_fp("post-rst", 1'b1, 1'b1, 8'd1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
